hazard_sched: RTL

HAZARD_SCHED -- requirements
Module: hazard_sched

---
 rtl/hazard_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_sched.sv
// hazard_sched: hazard unit for a five-stage in-order pipeline.
// It keeps its own shadow of the Execute, Memory and Writeback slots. From
// these and the Decode-stage request it produces stall, flush and forwarding
// controls. It also runs a memory-wait watchdog and counts load-use stall
// cycles.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   Rs1D, Rs2D, UseRs1D, UseRs2D  Decode source registers and their use flags
//   RdD, RegWriteD, ResultSrcD    Decode destination, write enable, result
//                                 source (2'b01 = load)
//   PCSrcE                        taken branch/jump resolved in Execute
//   MemBusyM                      data memory not ready in the Memory stage
//   StallF/D/E/M, FlushD/E        pipeline-register controls (combinational)
//   ForwardAE, ForwardBE          10 = Memory ALU result, 01 = Writeback,
//                                 00 = register file
//   MemTimeout                    sticky watchdog flag
//   StallCount                    saturating count of load-use stall cycles
//
// Per-cycle mode (the highest-priority condition wins)
//   mode     | meaning
//   MEMWAIT  | memory busy: stall every stage, hold E/M, W gets a bubble
//   REDIRECT | taken branch: flush D and E, bubble into E
//   LOADUSE  | Decode needs a load still in E: stall F/D, bubble into E
//   RUN      | normal advance
module hazard_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        UseRs1D,
    input  logic        UseRs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic [1:0]  ResultSrcD,
    input  logic        PCSrcE,
    input  logic        MemBusyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [15:0] StallCount
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       isload;
    } slot_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOADUSE  = 2'd1,
        REDIRECT = 2'd2,
        MEMWAIT  = 2'd3
    } mode_t;

    slot_t       e_q, m_q, w_q;
    logic [4:0]  e_rs1_q, e_rs2_q;
    logic [7:0]  wait_cnt_q, wait_cnt_nxt;
    logic        timeout_q;
    logic [15:0] stall_cnt_q;
    mode_t       mode;
    logic        load_use;

    // A producer in slot s can feed register rs; x0 never matches.
    function automatic logic hits(input slot_t s, input logic [4:0] rs);
        return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hits(m_q, rs))
            return 2'b10;
        else if (hits(w_q, rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        load_use = e_q.valid && e_q.isload && e_q.regwrite && (e_q.rd != 5'd0) &&
                   ((UseRs1D && (Rs1D == e_q.rd)) || (UseRs2D && (Rs2D == e_q.rd)));

        if (MemBusyM)
            mode = MEMWAIT;
        else if (PCSrcE)
            mode = REDIRECT;
        else if (load_use)
            mode = LOADUSE;
        else
            mode = RUN;

        if (!MemBusyM)
            wait_cnt_nxt = 8'd0;
        else if (wait_cnt_q != 8'hFF)
            wait_cnt_nxt = wait_cnt_q + 8'd1;
        else
            wait_cnt_nxt = wait_cnt_q;
    end

    // Controls are forced low while reset is held, whatever the inputs say.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst_n) begin
            case (mode)
                MEMWAIT: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                end
                REDIRECT: begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end
                LOADUSE: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slots are cleared in reset, so forwarding is naturally 00 there.
    assign ForwardAE  = fwd_sel(e_rs1_q);
    assign ForwardBE  = fwd_sel(e_rs2_q);
    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            e_rs1_q     <= 5'd0;
            e_rs2_q     <= 5'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            case (mode)
                MEMWAIT: begin
                    w_q <= '0;
                end
                LOADUSE, REDIRECT: begin
                    e_q     <= '0;
                    e_rs1_q <= 5'd0;
                    e_rs2_q <= 5'd0;
                    m_q     <= e_q;
                    w_q     <= m_q;
                end
                default: begin
                    e_q     <= {1'b1, RdD, RegWriteD, (ResultSrcD == 2'b01)};
                    e_rs1_q <= Rs1D;
                    e_rs2_q <= Rs2D;
                    m_q     <= e_q;
                    w_q     <= m_q;
                end
            endcase

            wait_cnt_q <= wait_cnt_nxt;
            if (wait_cnt_nxt == 8'hFF)
                timeout_q <= 1'b1;

            if ((mode == LOADUSE) && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule
